// File: rtl/req_arbiter3_pkg.sv
`default_nettype none
// ============================================================================
// Package : arb_pkg
// Brief   : Shared constants, state encoding and rotation helper for the
//           three-way round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int TO_W    = 8;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT   = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_GRANT   = ST_GRANT,
    S_RELEASE = ST_RELEASE
  } arb_state_e;

  // Next requester index in the 0 -> 1 -> 2 -> 0 ring
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_arbiter3_if.sv
`default_nettype none
// ============================================================================
// Interface: req_arbiter3_if
// Brief    : Request/grant bundle between three requesters and the arbiter.
//            master = requester side, slave = arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface req_arbiter3_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         gnt_id;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/req_arbiter3_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick3
// Brief   : Combinational rotating-priority picker. Searches last+1, last+2,
//           last (mod 3) and returns the first requester found.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick3
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [NUM_REQ-1:0] pick,
  output logic [1:0]         pick_id,
  output logic               any
);

  logic [1:0] first_idx;
  logic [1:0] second_idx;
  logic [1:0] third_idx;

  assign first_idx  = rr_next(last);
  assign second_idx = rr_next(first_idx);
  assign third_idx  = rr_next(second_idx);
  assign any        = |req;

  // Priority search in rotated order; pick stays zero when nothing requests
  always_comb begin
    pick    = '0;
    pick_id = 2'd0;
    if (req[first_idx]) begin
      pick_id = first_idx;
    end else if (req[second_idx]) begin
      pick_id = second_idx;
    end else begin
      pick_id = third_idx;
    end
    if (any) begin
      pick = NUM_REQ'(1) << pick_id;
    end else begin
      pick_id = 2'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/req_arbiter3.sv
`default_nettype none
// ============================================================================
// Module  : req_arbiter3
// Brief   : Round-robin arbiter for one shared resource and three requesters.
//           IDLE -> GRANT (held until done/req drop) -> RELEASE (1 cycle gap).
//           Optional watchdog enabled by macro ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module req_arbiter3
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  req_arbiter3_if.slave    bus
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic [1:0]         last_q, last_d;

  logic [NUM_REQ-1:0] pick;
  logic [1:0]         pick_id;
  logic               any_req;
  logic               own_exit;
  logic               to_hit;

  rr_pick3 u_pick (
    .req     (bus.req),
    .last    (last_q),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (any_req)
  );

  // Owner finished or withdrew its request; non-owner bits are ignored
  assign own_exit = bus.done[gnt_id_q] | ~bus.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;

  // Counter is zero in the first GRANT cycle, so TIMEOUT-1 marks the last allowed cycle
  assign to_hit          = (state_q == S_GRANT) && (cnt_q == TO_W'(TIMEOUT - 1));
  assign bus.timeout_err = timeout_err_q;
`else
  logic [TO_W-1:0] unused_timeout;

  assign unused_timeout  = TO_W'(TIMEOUT);
  assign to_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state and next-output computation
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d    = pick;
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
          state_d  = S_GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_GRANT: begin
        if (own_exit || to_hit) begin
          gnt_d    = '0;
          gnt_id_d = 2'd0;
          busy_d   = 1'b0;
          last_d   = gnt_id_q;
          state_d  = S_RELEASE;
`ifdef ARB_TIMEOUT_EN
          // A normal exit in the same cycle wins over the watchdog
          timeout_err_d = ~own_exit;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + TO_W'(1);
`endif
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        gnt_id_d = 2'd0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
      last_q   <= 2'd2;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog hold counter and error pulse register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter3.sv
`default_nettype none
// ============================================================================
// Module  : tb_req_arbiter3
// Brief   : Self-checking bench for req_arbiter3 with an expectation queue.
//           Build with ARB_TIMEOUT_EN defined to exercise the watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module tb_req_arbiter3;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 16;
`endif

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       terr;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  obs_t exp_q[$];

  req_arbiter3_if bus_if();

  req_arbiter3 #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs implied by a grant vector: id is the one-hot index
  function automatic obs_t mk(input logic [2:0] g, input logic terr);
    obs_t r;
    r.gnt  = g;
    r.id   = g[1] ? 2'd1 : (g[2] ? 2'd2 : 2'd0);
    r.busy = |g;
    r.terr = terr;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.gnt  = bus_if.gnt;
    r.id   = bus_if.gnt_id;
    r.busy = bus_if.busy;
    r.terr = bus_if.timeout_err;
    return r;
  endfunction

  task automatic flush();
    bus_if.req  = 3'b000;
    bus_if.done = 3'b000;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n       = 1'b0;
    bus_if.req  = 3'b111;
    bus_if.done = 3'b000;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(3'b000, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", k,
                 o.gnt, o.id, o.busy, o.terr, e.gnt, e.id, e.busy, e.terr);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    obs_t e, o;
    logic [2:0] seq [10] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000,
                             3'b000, 3'b100, 3'b000, 3'b000, 3'b001};
    logic [2:0] prev = 3'b000;
    bus_if.req = 3'b111;
    for (int k = 0; k < 10; k++) begin
      // owner pulses done during its first (and only) grant cycle
      bus_if.done = prev;
      exp_q.push_back(mk(seq[k], 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rotation[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", k,
                 o.gnt, o.id, o.busy, o.terr, e.gnt, e.id, e.busy, e.terr);
      end
      prev = seq[k];
    end
    flush();
  endtask

  task automatic test_single();
    obs_t e, o;
    logic [2:0] rq [6] = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000};
    logic [2:0] gx [6] = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000};
    bus_if.done = 3'b000;
    for (int k = 0; k < 6; k++) begin
      bus_if.req = rq[k];
      exp_q.push_back(mk(gx[k], 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", k,
                 o.gnt, o.id, o.busy, o.terr, e.gnt, e.id, e.busy, e.terr);
      end
    end
    flush();
  endtask

  task automatic test_foreign_done();
    obs_t e, o;
    logic [2:0] dn [7] = '{3'b000, 3'b010, 3'b010, 3'b001, 3'b000, 3'b000, 3'b010};
    logic [2:0] gx [7] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000};
    bus_if.req = 3'b011;
    for (int k = 0; k < 7; k++) begin
      bus_if.done = dn[k];
      exp_q.push_back(mk(gx[k], 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL foreign_done[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", k,
                 o.gnt, o.id, o.busy, o.terr, e.gnt, e.id, e.busy, e.terr);
      end
    end
    flush();
  endtask

  task automatic test_timeout();
    obs_t e, o;
`ifdef ARB_TIMEOUT_EN
    logic [2:0] rq [8] = '{3'b010, 3'b010, 3'b010, 3'b010,
                           3'b010, 3'b010, 3'b010, 3'b000};
    logic [2:0] gx [8] = '{3'b010, 3'b010, 3'b010, 3'b010,
                           3'b000, 3'b000, 3'b010, 3'b000};
    logic       te [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    logic [2:0] rq [8] = '{3'b010, 3'b010, 3'b010, 3'b010,
                           3'b010, 3'b010, 3'b010, 3'b010};
    logic [2:0] gx [8] = '{3'b010, 3'b010, 3'b010, 3'b010,
                           3'b010, 3'b010, 3'b010, 3'b010};
    logic       te [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    bus_if.done = 3'b000;
    for (int k = 0; k < 8; k++) begin
      bus_if.req = rq[k];
      exp_q.push_back(mk(gx[k], te[k]));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL timeout[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", k,
                 o.gnt, o.id, o.busy, o.terr, e.gnt, e.id, e.busy, e.terr);
      end
    end
    flush();
  endtask

  task automatic test_reset_mid_grant();
    obs_t e, o;
    logic [2:0] rq [4] = '{3'b010, 3'b111, 3'b111, 3'b000};
    logic       rs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] gx [4] = '{3'b010, 3'b000, 3'b001, 3'b000};
    bus_if.done = 3'b000;
    for (int k = 0; k < 4; k++) begin
      bus_if.req = rq[k];
      rst_n      = rs[k];
      exp_q.push_back(mk(gx[k], 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", k,
                 o.gnt, o.id, o.busy, o.terr, e.gnt, e.id, e.busy, e.terr);
      end
    end
    flush();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.req  = 3'b000;
    bus_if.done = 3'b000;
    test_reset();
    test_rotation();
    test_single();
    test_foreign_done();
    test_timeout();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
